traffic_phase_controller: RTL and testbench

- Sequences the two-road intersection.
- Steps principal/secondary green and amber phases using operator-set durations.
- Produces the road and pedestrian lamp codes, plus the timeRemaining, StateFlag and PhraseSel values that drive the LCD output path.
- Also provides a night flashing mode and a pedestrian-request shortening of the principal green.

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/traffic_phase_controller_if.sv | 28 ++
 rtl/traffic_phase_controller_sec_tick_gen.sv | 23 ++
 rtl/traffic_phase_controller.sv | 123 ++++++++++++
 tb/tb_traffic_phase_controller.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared phase encoding, lamp codes and duration clamping for the intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    P_GREEN,
    P_AMBER,
    S_GREEN,
    S_AMBER,
    FLASH
  } state_t;

  localparam logic [2:0] ROAD_RED   = 3'b100;
  localparam logic [2:0] ROAD_AMBER = 3'b010;
  localparam logic [2:0] ROAD_GREEN = 3'b001;
  localparam logic [2:0] ROAD_OFF   = 3'b000;
  localparam logic [1:0] PED_RED    = 2'b10;
  localparam logic [1:0] PED_GREEN  = 2'b01;

  localparam logic [1:0] PH_PRINCIPAL = 2'd0;
  localparam logic [1:0] PH_SECONDARY = 2'd1;
  localparam logic [1:0] PH_NIGHT     = 2'd2;

  // Zero would never expire and the display only has two digits.
  function automatic logic [6:0] dur(input logic [6:0] x, input logic [6:0] tmax);
    if (x == 7'd0)
      return 7'd1;
    else if (x > tmax)
      return tmax;
    else
      return x;
  endfunction

endpackage

// File: rtl/traffic_phase_controller_if.sv
// Operator settings in, lamp/LCD drive out; master is the controller side.
interface traffic_phase_controller_if;
  logic [6:0] Tpv;
  logic [6:0] Tsv;
  logic [6:0] Ta;
  logic       ped_req;
  logic       night_mode;
  logic [2:0] Principal_Road;
  logic [2:0] Secondary_Road;
  logic [1:0] Principal_Pedestrian;
  logic [1:0] Secondary_Pedestrian;
  logic [6:0] timeRemaining;
  logic [1:0] StateFlag;
  logic [1:0] PhraseSel;
  logic       sec_tick;

  modport master (
    input  Tpv, Tsv, Ta, ped_req, night_mode,
    output Principal_Road, Secondary_Road, Principal_Pedestrian, Secondary_Pedestrian,
    output timeRemaining, StateFlag, PhraseSel, sec_tick
  );

  modport slave (
    output Tpv, Tsv, Ta, ped_req, night_mode,
    input  Principal_Road, Secondary_Road, Principal_Pedestrian, Secondary_Pedestrian,
    input  timeRemaining, StateFlag, PhraseSel, sec_tick
  );
endinterface

// File: rtl/traffic_phase_controller_sec_tick_gen.sv
// Free-running 1 s prescaler; sec_tick is high for the single cycle the count sits at TICK_DIV-1.
module sec_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  output logic sec_tick
);
  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

  assign sec_tick = (cnt == LAST);

endmodule

// File: rtl/traffic_phase_controller.sv
// Two-road phase sequencer with pedestrian green shortening and night flashing.
// All lamp/LCD outputs are registered and show the new phase the cycle after the tick edge.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int PED_CUT  = 5,
  parameter int T_MAX    = 99
) (
  input  logic                        clock50MHz,
  input  logic                        reset,
  traffic_phase_controller_if.master  bus
);
  localparam logic [6:0] TMAX = 7'(T_MAX);
  localparam logic [6:0] CUT  = 7'(PED_CUT);

  state_t     state, nxt_state;
  logic [6:0] tr, nxt_tr;
  logic       ped, nxt_ped;
  logic       blink, nxt_blink;
  logic       tick;
  logic [2:0] pr, sr;
  logic [1:0] pp, sp, sf, ph;

  sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk      (clock50MHz),
    .reset    (reset),
    .sec_tick (tick)
  );

  always_comb begin
    nxt_state = state;
    nxt_tr    = tr;
    nxt_blink = blink;
    nxt_ped   = ped | (state == P_GREEN && bus.ped_req);
    if (tick) begin
      if (bus.night_mode && state != FLASH) begin
        nxt_state = FLASH;
        nxt_tr    = '0;
        nxt_ped   = 1'b0;
        nxt_blink = 1'b1;
      end else if (state == FLASH) begin
        if (bus.night_mode) begin
          nxt_blink = ~blink;
        end else begin
          nxt_state = P_GREEN;
          nxt_tr    = dur(bus.Tpv, TMAX);
          nxt_blink = 1'b1;
        end
      end else if (tr <= 7'd1) begin
        // Leaving P_GREEN drops any pending request, including one raised this cycle.
        nxt_ped = 1'b0;
        case (state)
          P_GREEN: begin nxt_state = P_AMBER; nxt_tr = dur(bus.Ta,  TMAX); end
          P_AMBER: begin nxt_state = S_GREEN; nxt_tr = dur(bus.Tsv, TMAX); end
          S_GREEN: begin nxt_state = S_AMBER; nxt_tr = dur(bus.Ta,  TMAX); end
          default: begin nxt_state = P_GREEN; nxt_tr = dur(bus.Tpv, TMAX); end
        endcase
      end else begin
        nxt_tr = tr - 7'd1;
        if (state == P_GREEN && ped) begin
          nxt_ped = 1'b0;
          if (tr > CUT)
            nxt_tr = CUT;
        end
      end
    end
  end

  always_ff @(posedge clock50MHz) begin
    if (reset) begin
      state <= P_GREEN;
      tr    <= dur(bus.Tpv, TMAX);
      ped   <= 1'b0;
      blink <= 1'b1;
      sf    <= 2'd0;
      ph    <= PH_PRINCIPAL;
      pr    <= ROAD_GREEN;
      sr    <= ROAD_RED;
      pp    <= PED_RED;
      sp    <= PED_GREEN;
    end else begin
      state <= nxt_state;
      tr    <= nxt_tr;
      ped   <= nxt_ped;
      blink <= nxt_blink;
      case (nxt_state)
        P_GREEN: begin
          sf <= 2'd0; ph <= PH_PRINCIPAL;
          pr <= ROAD_GREEN; sr <= ROAD_RED; pp <= PED_RED; sp <= PED_GREEN;
        end
        P_AMBER: begin
          sf <= 2'd1; ph <= PH_PRINCIPAL;
          pr <= ROAD_AMBER; sr <= ROAD_RED; pp <= PED_RED; sp <= PED_RED;
        end
        S_GREEN: begin
          sf <= 2'd2; ph <= PH_SECONDARY;
          pr <= ROAD_RED; sr <= ROAD_GREEN; pp <= PED_GREEN; sp <= PED_RED;
        end
        S_AMBER: begin
          sf <= 2'd3; ph <= PH_SECONDARY;
          pr <= ROAD_RED; sr <= ROAD_AMBER; pp <= PED_RED; sp <= PED_RED;
        end
        default: begin
          sf <= 2'd1; ph <= PH_NIGHT;
          pr <= nxt_blink ? ROAD_AMBER : ROAD_OFF;
          sr <= nxt_blink ? ROAD_AMBER : ROAD_OFF;
          pp <= PED_RED; sp <= PED_RED;
        end
      endcase
    end
  end

  assign bus.Principal_Road       = pr;
  assign bus.Secondary_Road       = sr;
  assign bus.Principal_Pedestrian = pp;
  assign bus.Secondary_Pedestrian = sp;
  assign bus.timeRemaining        = tr;
  assign bus.StateFlag            = sf;
  assign bus.PhraseSel            = ph;
  assign bus.sec_tick             = tick;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller with a 4-cycle second.
module tb_traffic_phase_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rst_cyc = 0;

  traffic_phase_controller_if bus();

  traffic_phase_controller #(.TICK_DIV(4), .PED_CUT(5), .T_MAX(99)) dut (
    .clock50MHz (clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {StateFlag, PhraseSel, PR, SR, PP, SP, timeRemaining}
  logic [20:0] obs;
  assign obs = {bus.StateFlag, bus.PhraseSel, bus.Principal_Road, bus.Secondary_Road,
                bus.Principal_Pedestrian, bus.Secondary_Pedestrian, bus.timeRemaining};

  localparam logic [13:0] LP_PG  = {2'd0, 2'd0, 3'b001, 3'b100, 2'b10, 2'b01};
  localparam logic [13:0] LP_PA  = {2'd1, 2'd0, 3'b010, 3'b100, 2'b10, 2'b10};
  localparam logic [13:0] LP_SG  = {2'd2, 2'd1, 3'b100, 3'b001, 2'b01, 2'b10};
  localparam logic [13:0] LP_SA  = {2'd3, 2'd1, 3'b100, 3'b010, 2'b10, 2'b10};
  localparam logic [13:0] LP_FON = {2'd1, 2'd2, 3'b010, 3'b010, 2'b10, 2'b10};
  localparam logic [13:0] LP_FOF = {2'd1, 2'd2, 3'b000, 3'b000, 2'b10, 2'b10};

  task automatic do_reset(input logic [6:0] tpv, input logic [6:0] ta, input logic [6:0] tsv);
    bus.Tpv = tpv; bus.Ta = ta; bus.Tsv = tsv;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rst_cyc = cyc;
  endtask

  // Returns at the negedge just after the next sec_tick edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      int waited = 0;
      while (bus.sec_tick !== 1'b1 && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      checks++;
      if (bus.sec_tick !== 1'b1) begin
        errors++;
        $display("FAIL tick_timeout: sec_tick=%b after %0d cycles, required 1", bus.sec_tick, waited);
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_ped();
    bus.ped_req = 1'b1;
    @(negedge clk);
    bus.ped_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(7'd5, 7'd2, 7'd3);
    checks++; if (obs !== {LP_PG, 7'd5}) begin errors++; $display("FAIL reset_state got=%h exp=%h", obs, {LP_PG, 7'd5}); end
    checks++; if (bus.sec_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", bus.sec_tick); end
  endtask

  task automatic test_cycle();
    step(4); checks++; if (obs !== {LP_PG, 7'd1}) begin errors++; $display("FAIL cyc_pg1 got=%h exp=%h", obs, {LP_PG, 7'd1}); end
    step(1); checks++; if (obs !== {LP_PA, 7'd2}) begin errors++; $display("FAIL cyc_pa got=%h exp=%h", obs, {LP_PA, 7'd2}); end
    step(2); checks++; if (obs !== {LP_SG, 7'd3}) begin errors++; $display("FAIL cyc_sg got=%h exp=%h", obs, {LP_SG, 7'd3}); end
    step(3); checks++; if (obs !== {LP_SA, 7'd2}) begin errors++; $display("FAIL cyc_sa got=%h exp=%h", obs, {LP_SA, 7'd2}); end
    step(2); checks++; if (obs !== {LP_PG, 7'd5}) begin errors++; $display("FAIL cyc_wrap got=%h exp=%h", obs, {LP_PG, 7'd5}); end
    checks++; if (cyc - rst_cyc !== 48) begin errors++; $display("FAIL cyc_len got=%0d exp=48", cyc - rst_cyc); end
  endtask

  task automatic test_clamp();
    do_reset(7'd0, 7'd2, 7'd120);
    checks++; if (obs !== {LP_PG, 7'd1}) begin errors++; $display("FAIL clamp_zero got=%h exp=%h", obs, {LP_PG, 7'd1}); end
    step(1); checks++; if (obs !== {LP_PA, 7'd2}) begin errors++; $display("FAIL clamp_onetick got=%h exp=%h", obs, {LP_PA, 7'd2}); end
    step(2); checks++; if (obs !== {LP_SG, 7'd99}) begin errors++; $display("FAIL clamp_max got=%h exp=%h", obs, {LP_SG, 7'd99}); end
    step(1); checks++; if (obs !== {LP_SG, 7'd98}) begin errors++; $display("FAIL clamp_dec got=%h exp=%h", obs, {LP_SG, 7'd98}); end
  endtask

  task automatic test_midphase();
    do_reset(7'd5, 7'd1, 7'd1);
    step(2); checks++; if (obs !== {LP_PG, 7'd3}) begin errors++; $display("FAIL mid_pg3 got=%h exp=%h", obs, {LP_PG, 7'd3}); end
    bus.Tpv = 7'd9;
    step(2); checks++; if (obs !== {LP_PG, 7'd1}) begin errors++; $display("FAIL mid_pg1 got=%h exp=%h", obs, {LP_PG, 7'd1}); end
    step(1); checks++; if (obs !== {LP_PA, 7'd1}) begin errors++; $display("FAIL mid_pa got=%h exp=%h", obs, {LP_PA, 7'd1}); end
    step(2); checks++; if (obs !== {LP_SA, 7'd1}) begin errors++; $display("FAIL mid_sa got=%h exp=%h", obs, {LP_SA, 7'd1}); end
    step(1); checks++; if (obs !== {LP_PG, 7'd9}) begin errors++; $display("FAIL mid_reload got=%h exp=%h", obs, {LP_PG, 7'd9}); end
  endtask

  task automatic test_ped();
    do_reset(7'd20, 7'd2, 7'd3);
    step(2); checks++; if (obs !== {LP_PG, 7'd18}) begin errors++; $display("FAIL ped_pre got=%h exp=%h", obs, {LP_PG, 7'd18}); end
    pulse_ped();
    step(1); checks++; if (obs !== {LP_PG, 7'd5}) begin errors++; $display("FAIL ped_cut got=%h exp=%h", obs, {LP_PG, 7'd5}); end
    step(2); checks++; if (obs !== {LP_PG, 7'd3}) begin errors++; $display("FAIL ped_dec got=%h exp=%h", obs, {LP_PG, 7'd3}); end
    pulse_ped();
    step(1); checks++; if (obs !== {LP_PG, 7'd2}) begin errors++; $display("FAIL ped_noext got=%h exp=%h", obs, {LP_PG, 7'd2}); end
    step(1); checks++; if (obs !== {LP_PG, 7'd1}) begin errors++; $display("FAIL ped_pg1 got=%h exp=%h", obs, {LP_PG, 7'd1}); end
    bus.ped_req = 1'b1;
    step(1);
    bus.ped_req = 1'b0;
    checks++; if (obs !== {LP_PA, 7'd2}) begin errors++; $display("FAIL ped_expiry got=%h exp=%h", obs, {LP_PA, 7'd2}); end
    step(2); checks++; if (obs !== {LP_SG, 7'd3}) begin errors++; $display("FAIL ped_sg got=%h exp=%h", obs, {LP_SG, 7'd3}); end
    pulse_ped();
    step(1); checks++; if (obs !== {LP_SG, 7'd2}) begin errors++; $display("FAIL ped_in_sg got=%h exp=%h", obs, {LP_SG, 7'd2}); end
    step(4); checks++; if (obs !== {LP_PG, 7'd20}) begin errors++; $display("FAIL ped_reload got=%h exp=%h", obs, {LP_PG, 7'd20}); end
    step(1); checks++; if (obs !== {LP_PG, 7'd19}) begin errors++; $display("FAIL ped_dropped got=%h exp=%h", obs, {LP_PG, 7'd19}); end
  endtask

  task automatic test_night();
    do_reset(7'd5, 7'd2, 7'd3);
    step(7); checks++; if (obs !== {LP_SG, 7'd3}) begin errors++; $display("FAIL night_sg got=%h exp=%h", obs, {LP_SG, 7'd3}); end
    bus.night_mode = 1'b1;
    step(1); checks++; if (obs !== {LP_FON, 7'd0}) begin errors++; $display("FAIL night_on1 got=%h exp=%h", obs, {LP_FON, 7'd0}); end
    step(1); checks++; if (obs !== {LP_FOF, 7'd0}) begin errors++; $display("FAIL night_off got=%h exp=%h", obs, {LP_FOF, 7'd0}); end
    step(1); checks++; if (obs !== {LP_FON, 7'd0}) begin errors++; $display("FAIL night_on2 got=%h exp=%h", obs, {LP_FON, 7'd0}); end
    bus.night_mode = 1'b0;
    step(1); checks++; if (obs !== {LP_PG, 7'd5}) begin errors++; $display("FAIL night_exit got=%h exp=%h", obs, {LP_PG, 7'd5}); end
    step(4); checks++; if (obs !== {LP_PG, 7'd1}) begin errors++; $display("FAIL night_pg1 got=%h exp=%h", obs, {LP_PG, 7'd1}); end
    bus.night_mode = 1'b1;
    step(1); checks++; if (obs !== {LP_FON, 7'd0}) begin errors++; $display("FAIL night_over_expiry got=%h exp=%h", obs, {LP_FON, 7'd0}); end
    bus.night_mode = 1'b0;
    step(1); checks++; if (obs !== {LP_PG, 7'd5}) begin errors++; $display("FAIL night_exit2 got=%h exp=%h", obs, {LP_PG, 7'd5}); end
  endtask

  task automatic test_reset_mid();
    logic exp_tick;
    do_reset(7'd5, 7'd2, 7'd3);
    step(8); checks++; if (obs !== {LP_SG, 7'd2}) begin errors++; $display("FAIL rmid_sg got=%h exp=%h", obs, {LP_SG, 7'd2}); end
    @(negedge clk);
    do_reset(7'd7, 7'd2, 7'd3);
    checks++; if (obs !== {LP_PG, 7'd7}) begin errors++; $display("FAIL rmid_state got=%h exp=%h", obs, {LP_PG, 7'd7}); end
    checks++; if (bus.sec_tick !== 1'b0) begin errors++; $display("FAIL rmid_tick0 got=%b exp=0", bus.sec_tick); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      exp_tick = (i == 3);
      checks++; if (bus.sec_tick !== exp_tick) begin errors++; $display("FAIL rmid_tick_c%0d got=%b exp=%b", i, bus.sec_tick, exp_tick); end
    end
    step(1); checks++; if (obs !== {LP_PG, 7'd6}) begin errors++; $display("FAIL rmid_first got=%h exp=%h", obs, {LP_PG, 7'd6}); end
  endtask

  initial begin
    bus.ped_req = 1'b0;
    bus.night_mode = 1'b0;
    bus.Tpv = 7'd5; bus.Ta = 7'd2; bus.Tsv = 7'd3;
    test_reset();
    test_cycle();
    test_clamp();
    test_midphase();
    test_ped();
    test_night();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
